// File: rtl/stdout_pkg.sv
// Shared definitions for the stdout serial console: FSM encoding, data width, idle level.
// Optional build macro used by the consumers of this package: STDOUT_PARIDADE_EN.
package stdout_pkg;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    INICIO   = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    PARADA   = 3'd4
  } estado_t;

  localparam int   BITS_DADOS   = 8;
  localparam logic LINHA_OCIOSA = 1'b1;

endpackage

// File: rtl/fifo_stdout.sv
// Byte FIFO with first-word-fall-through head; a push on a full FIFO is accepted only
// when a pop frees a slot on the same edge.
module fifo_stdout #(
  parameter int PROF_FIFO = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] dado_in,
  input  logic       pop,
  output logic [7:0] dado_out,
  output logic       vazia,
  output logic       cheia
);

  localparam int PW = $clog2(PROF_FIFO);

  logic [7:0]    mem [PROF_FIFO];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cont;
  logic          do_pop;
  logic          do_push;

  assign vazia    = (cont == '0);
  assign cheia    = (cont == (PW+1)'(PROF_FIFO));
  assign do_pop   = pop & ~vazia;
  assign do_push  = push & (~cheia | do_pop);
  assign dado_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= dado_in;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cont   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cont <= cont + 1'b1;
        2'b01:   cont <= cont - 1'b1;
        default: cont <= cont;
      endcase
    end
  end

endmodule

// File: rtl/transmissor_stdout.sv
// Stdout console: buffers stored bytes in a FIFO and sends them as 8N1 serial frames.
// Define STDOUT_PARIDADE_EN to insert an even-parity bit (8E1 frames).
module transmissor_stdout
  import stdout_pkg::*;
#(
  parameter int CLKS_POR_BIT = 16,
  parameter int PROF_FIFO    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] stdout,
  input  logic        stdout_we,
  output logic        tx,
  output logic        ocupado,
  output logic        fifo_cheia,
  output logic        transbordo
);

  localparam int BW = (CLKS_POR_BIT > 1) ? $clog2(CLKS_POR_BIT) : 1;

  estado_t         estado;
  logic [BW-1:0]   baud;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic [7:0]      cabeca;
  logic            vazia;
  logic            baud_fim;
  logic            pop;
  logic            bits_sobra_unused;

  assign bits_sobra_unused = ^stdout[31:8];
  assign baud_fim = (baud == BW'(CLKS_POR_BIT - 1));
  assign ocupado  = (estado != OCIOSO);
  // The FSM pops exactly when it loads a new byte: from idle, or at the end of a stop bit.
  assign pop = ~vazia & ((estado == OCIOSO) | ((estado == PARADA) & baud_fim));

  fifo_stdout #(.PROF_FIFO(PROF_FIFO)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (stdout_we),
    .dado_in  (stdout[7:0]),
    .pop      (pop),
    .dado_out (cabeca),
    .vazia    (vazia),
    .cheia    (fifo_cheia)
  );

  always_ff @(posedge clk) begin
    if (pop)
      shift <= cabeca;
    else if ((estado == DADOS) && baud_fim)
      shift <= shift >> 1;
  end

`ifdef STDOUT_PARIDADE_EN
  logic paridade;

  always_ff @(posedge clk) begin
    if (pop) paridade <= ^cabeca;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado     <= OCIOSO;
      tx         <= LINHA_OCIOSA;
      baud       <= '0;
      bit_cnt    <= '0;
      transbordo <= 1'b0;
    end else begin
      if (stdout_we && fifo_cheia && !pop) transbordo <= 1'b1;
      case (estado)
        OCIOSO: begin
          tx <= LINHA_OCIOSA;
          if (!vazia) begin
            baud    <= '0;
            bit_cnt <= '0;
            estado  <= INICIO;
            tx      <= 1'b0;
          end
        end
        INICIO: begin
          if (baud_fim) begin
            baud   <= '0;
            estado <= DADOS;
            tx     <= shift[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DADOS: begin
          if (baud_fim) begin
            baud    <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'(BITS_DADOS - 1)) begin
`ifdef STDOUT_PARIDADE_EN
              estado <= PARIDADE;
              tx     <= paridade;
`else
              estado <= PARADA;
              tx     <= 1'b1;
`endif
            end else begin
              tx <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
`ifdef STDOUT_PARIDADE_EN
        PARIDADE: begin
          if (baud_fim) begin
            baud   <= '0;
            estado <= PARADA;
            tx     <= 1'b1;
          end else begin
            baud <= baud + 1'b1;
          end
        end
`endif
        PARADA: begin
          if (baud_fim) begin
            baud <= '0;
            if (!vazia) begin
              bit_cnt <= '0;
              estado  <= INICIO;
              tx      <= 1'b0;
            end else begin
              estado <= OCIOSO;
              tx     <= LINHA_OCIOSA;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          estado <= OCIOSO;
          tx     <= LINHA_OCIOSA;
          baud   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/transmissor_stdout.md
# transmissor_stdout

Serial console stage downstream of the processor's `stdout` port. Each store to the stdout word pushes its low byte into a small FIFO. An 8N1 UART transmitter then drains the FIFO onto a single `tx` line. This decouples single-cycle program execution from the slow serial rate.

## Interface
Parameters:
- `CLKS_POR_BIT`, default 16: clock cycles per serial bit. Must be at least 2.
- `PROF_FIFO`, default 4: FIFO depth in bytes. Must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stdout`  in  32  data word from the data memory; only bits [7:0] are used.
- `stdout_we`  in  1  one-cycle strobe, high when the processor writes the stdout word (MemWrite qualified by the stdout address).
- `tx`  out  1  serial line, idle high.
- `ocupado`  out  1  transmitter FSM is not in OCIOSO.
- `fifo_cheia`  out  1  FIFO holds `PROF_FIFO` bytes.
- `transbordo`  out  1  sticky flag: a write was dropped because the FIFO was full.

## Operation
- **Push:** on a clock edge with `stdout_we=1`, `stdout[7:0]` is written at the tail, unless the FIFO is full.
- **Full write:** the byte is dropped and `transbordo` is set.
  - `transbordo` stays set until reset.
  - Exception: if a pop happens on the same edge, the write is accepted and the count is unchanged.
- **Empty:** pop happens only when the FIFO is not empty.
- **Pointers:** wrap modulo `PROF_FIFO`. Count width is log2(`PROF_FIFO`)+1 bits.
- **FSM states:** OCIOSO, INICIO, DADOS, [PARIDADE], PARADA.
- **OCIOSO:** `tx=1`. If the FIFO is not empty: pop the head into the shift register, clear the bit counter and baud counter, go to INICIO.
- **INICIO:** `tx=0` for `CLKS_POR_BIT` cycles, then go to DADOS.
- **DADOS:** `tx`=shift[0], LSB first. After each `CLKS_POR_BIT` cycles, shift right and increment the bit counter. After bit 7, go to PARIDADE if compiled in, otherwise to PARADA.
- **PARIDADE:** `tx`=XOR of the 8 data bits (even parity) for `CLKS_POR_BIT` cycles, then go to PARADA.
- **PARADA:** `tx=1` for `CLKS_POR_BIT` cycles. At the end:
  - if the FIFO is not empty, pop and go straight to INICIO (no idle gap);
  - otherwise go to OCIOSO.
- **Baud counter:** counts 0..`CLKS_POR_BIT`-1; the terminal count advances the bit.
- **Registered outputs:** `tx` is driven from a register, so it has no glitches.

## Timing
- **Reset values:** `tx=1`, `ocupado=0`, `fifo_cheia=0`, `transbordo=0`, FIFO empty, FSM in OCIOSO, all counters 0.
- **Reset mid-frame:** the frame is aborted immediately (asynchronous), `tx` returns to 1, and FIFO contents are discarded.
- **Push latency:** a write captured on edge N makes the FIFO non-empty after N. `fifo_cheia` updates on the same edge.
- **Idle start:** the FSM pops on edge N+1. `tx` falls and `ocupado` rises after N+1.
- **Frame length:** 10×`CLKS_POR_BIT` cycles, or 11× with parity.
- **Back-to-back frames:** the next start bit begins the cycle after the last stop-bit cycle.
- **Continuous streaming:** throughput is one byte per frame time. Writes faster than that fill the FIFO; the excess is dropped and flagged.
- **`stdout_we` held high:** one push per cycle it is high. It is not edge-detected.

## Configuration
- `STDOUT_PARIDADE_EN` defined: the PARIDADE state exists, frames are 8E1, and frame length is 11 bit times.
- Undefined: 8N1, 10 bit times, and no parity logic is synthesized.

## Structure
- **Shared package `stdout_pkg`:**
  - FSM state encoding: OCIOSO=0, INICIO=1, DADOS=2, PARIDADE=3, PARADA=4, in 3 bits;
  - localparam `BITS_DADOS=8`;
  - idle line level constant.
- **Sub-module `fifo_stdout`:** parameterized by `PROF_FIFO`.
  - Ports: clk, rst_n, push, dado_in[7:0], pop, dado_out[7:0], vazia, cheia.
  - Output is first-word-fall-through (head visible combinationally).
- **Top:** holds the baud counter, bit counter, shift register, FSM and the `transbordo` flag.

## Test plan
- **Reset:** hold `rst_n=0` for 3 cycles, then release. Expect `tx=1`, `ocupado=0`, `fifo_cheia=0`, `transbordo=0`, and `tx` stays 1 for 100 idle cycles.
- **Single byte, `CLKS_POR_BIT=4`:** write `stdout=32'h00000041` with a one-cycle `stdout_we`. Expect:
  - `tx` low 2 edges after the write;
  - frame 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles, 40 cycles total;
  - then `ocupado=0`.
- **Back-to-back:** write 0x55 then 0xAA on consecutive cycles. Expect two frames with no idle cycle between stop and start. The upper 24 bits of `stdout` (set to 0xDEADBE) are ignored.
- **Overflow, `PROF_FIFO=4`:** 6 consecutive writes 0x30..0x35. Expect:
  - 0x30 popped immediately;
  - 0x31..0x34 buffered, `fifo_cheia=1`;
  - 0x35 dropped, `transbordo=1`;
  - output sequence 0x30..0x34.
- **Reset mid-frame:** assert `rst_n=0` during DADOS of byte 0x0F. Expect `tx=1` at once with no clock edge, and no frame after release.
- **Parity (macro defined):** byte 0x07. Expect parity bit 1, stop bit after it, frame of 11×`CLKS_POR_BIT` cycles.
